// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode 7-segment driver. It scans one digit per slot
// with dead time between slots, and supports blanking, blinking and leading-zero suppression.
module seg_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   DEAD_CNT   = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_blank;
    logic [DIGITS-1:0]   shadow_blink;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    idx;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic                wrap_q;

    logic [DIGITS-1:0]   lz_dark;
    logic                all_zero;
    logic [3:0]          nibble;
    logic                dark;
    logic [DIGITS-1:0]   an_sel;
    logic                slot_end;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // A digit is LZ-dark when it and every more-significant nibble are zero.
    always_comb begin
        all_zero = 1'b1;
        lz_dark  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (shadow_value[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_suppress && (i != 0) && all_zero;
        end
        nibble   = shadow_value[4*int'(idx) +: 4];
        dark     = shadow_blank[idx] | (shadow_blink[idx] & blink_phase) | lz_dark[idx];
        an_sel   = DIGITS'(1) << idx;
        slot_end = (count == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value <= '0;
            shadow_blank <= '0;
            shadow_blink <= '0;
            count        <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            wrap_q       <= 1'b0;
            seg_n        <= 7'h7F;
            an_n         <= '1;
            frame_done   <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_blank <= blank_mask;
                shadow_blink <= blink_mask;
            end

            if (slot_end) begin
                count <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                count <= count + CNT_W'(1);
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            // Pulse lands on the output cycle after the index wraps to 0.
            wrap_q     <= slot_end && (idx == IDX_LAST);
            frame_done <= wrap_q;

            if (count < DEAD_CNT) begin
                an_n  <= '1;
                seg_n <= 7'h7F;
            end else begin
                an_n  <= ~an_sel;
                seg_n <= dark ? 7'h7F : hex_to_seg(nibble);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: a cycle-count based reference model
// compared every cycle, plus directed literal checks for each scenario.
module tb_seg_scan_display;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int DL = 2;
    localparam int BD = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*D-1:0] value;
    logic [D-1:0]  blank_mask;
    logic [D-1:0]  blink_mask;
    logic          lz_suppress;
    logic          load;
    logic [6:0]    seg_n;
    logic [D-1:0]  an_n;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(
        .DIGITS(D), .REFRESH_DIV(RD), .DEAD(DL), .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .lz_suppress(lz_suppress),
        .load(load),
        .seg_n(seg_n),
        .an_n(an_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: k counts clock edges since reset release; slot, digit and
    // blink phase are derived from k arithmetically.
    int             k;
    logic [4*D-1:0] m_val;
    logic [D-1:0]   m_blank;
    logic [D-1:0]   m_blink;
    logic [6:0]     e_seg;
    logic [D-1:0]   e_an;
    logic           e_fd;
    bit             chk_en = 0;
    int             slot, dig;
    bit             ph, m_dark;

    always @(posedge clk) begin
        if (reset) begin
            k = 0;
            m_val = '0; m_blank = '0; m_blink = '0;
            e_seg = 7'h7F; e_an = '1; e_fd = 1'b0;
            chk_en = 1;
        end else begin
            slot = k % RD;
            dig  = (k / RD) % D;
            ph   = ((k / BD) % 2) == 1;
            e_fd = (k > 0) && (k % (RD * D) == 0);
            if (slot < DL) begin
                e_an  = '1;
                e_seg = 7'h7F;
            end else begin
                e_an   = ~(D'(1) << dig);
                m_dark = m_blank[dig] || (m_blink[dig] && ph) ||
                         (lz_suppress && dig > 0 && ((m_val >> (4 * dig)) == 0));
                e_seg  = m_dark ? 7'h7F : seg_tab[m_val[4*dig +: 4]];
            end
            if (load) begin
                m_val = value; m_blank = blank_mask; m_blink = blink_mask;
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (seg_n !== e_seg || an_n !== e_an || frame_done !== e_fd ||
                $countones(~an_n) > 1) begin
                errors++;
                $display("FAIL model t=%0t seg_n %h/%h an_n %b/%b frame_done %b/%b",
                         $time, seg_n, e_seg, an_n, e_an, frame_done, e_fd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Waits for the first live cycle of digit d (anode turning on after dead time).
    task automatic wait_live(input int d);
        logic [D-1:0] prev;
        logic [D-1:0] target;
        bit found;
        target = ~(D'(1) << d);
        prev   = an_n;
        found  = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (an_n == target && prev == '1) found = 1;
            prev = an_n;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_live digit %0d timeout an_n %b", d, an_n);
        end
    endtask

    task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] bl, input logic [D-1:0] bk);
        value = v; blank_mask = bl; blink_mask = bk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    int gap;
    int fd_cnt;
    bit seen_on, seen_off, seen_bad;
    bit got_fd;

    initial begin
        reset = 1'b1; value = '0; blank_mask = '0; blink_mask = '0;
        lz_suppress = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_seg", {25'd0, seg_n}, 32'h7F);
        chk("reset_an", {28'd0, an_n}, 32'hF);
        chk("reset_fd", {31'd0, frame_done}, 32'h0);
        reset = 1'b0;

        // Scan order and decode
        do_load(16'h1234, 4'b0000, 4'b0000);
        wait_live(0); chk("scan_d0", {25'd0, seg_n}, 32'h19); chk("scan_an0", {28'd0, an_n}, 32'hE);
        wait_live(1); chk("scan_d1", {25'd0, seg_n}, 32'h30); chk("scan_an1", {28'd0, an_n}, 32'hD);
        wait_live(2); chk("scan_d2", {25'd0, seg_n}, 32'h24); chk("scan_an2", {28'd0, an_n}, 32'hB);
        wait_live(3); chk("scan_d3", {25'd0, seg_n}, 32'h79); chk("scan_an3", {28'd0, an_n}, 32'h7);

        // frame_done period
        got_fd = 0;
        for (int n = 0; n < 100 && !got_fd; n++) begin
            @(negedge clk);
            if (frame_done) got_fd = 1;
        end
        chk("fd_seen", {31'd0, got_fd}, 32'h1);
        chk("fd_slot_dark", {28'd0, an_n}, 32'hF);
        gap = 0; fd_cnt = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) gap = n + 1;
            end
        end
        chk("fd_period", gap, 32);
        chk("fd_count", fd_cnt, 2);

        // Leading-zero suppression
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        wait_live(3); chk("lz_d3", {25'd0, seg_n}, 32'h7F);
        wait_live(0); chk("lz_d0", {25'd0, seg_n}, 32'h40);
        wait_live(1); chk("lz_d1", {25'd0, seg_n}, 32'h12);
        wait_live(2); chk("lz_d2", {25'd0, seg_n}, 32'h7F);
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_live(0); chk("lz0_d0", {25'd0, seg_n}, 32'h40);
        wait_live(1); chk("lz0_d1", {25'd0, seg_n}, 32'h7F);
        lz_suppress = 1'b0;
        wait_live(3); chk("nolz_d3", {25'd0, seg_n}, 32'h40);
        wait_live(1); chk("nolz_d1", {25'd0, seg_n}, 32'h40);

        // Blank and blink
        do_load(16'h8888, 4'b0001, 4'b1000);
        wait_live(0); chk("blank_d0", {25'd0, seg_n}, 32'h7F);
        wait_live(1); chk("blink_d1", {25'd0, seg_n}, 32'h00);
        wait_live(2); chk("blink_d2", {25'd0, seg_n}, 32'h00);
        seen_on = 0; seen_off = 0; seen_bad = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (an_n == 4'b0111) begin
                if (seg_n == 7'h00) seen_on = 1;
                else if (seg_n == 7'h7F) seen_off = 1;
                else seen_bad = 1;
            end
        end
        chk("blink_on", {31'd0, seen_on}, 32'h1);
        chk("blink_off", {31'd0, seen_off}, 32'h1);
        chk("blink_other", {31'd0, seen_bad}, 32'h0);

        // Load mid-slot
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        wait_live(0); chk("mid_pre", {25'd0, seg_n}, 32'h0E);
        value = 16'h000A; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("mid_load_edge", {25'd0, seg_n}, 32'h0E);
        @(negedge clk);
        chk("mid_after", {25'd0, seg_n}, 32'h08);
        chk("mid_after_an", {28'd0, an_n}, 32'hE);
        value = 16'h1234;
        wait_live(0); chk("noload_d0", {25'd0, seg_n}, 32'h08);
        wait_live(1); chk("noload_d1", {25'd0, seg_n}, 32'h40);

        // Reset mid-operation
        wait_live(2);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_an", {28'd0, an_n}, 32'hF);
        chk("mrst_seg", {25'd0, seg_n}, 32'h7F);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_dead", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        chk("mrst_relight_an", {28'd0, an_n}, 32'hE);
        chk("mrst_relight_seg", {25'd0, seg_n}, 32'h40);

        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Time-multiplexed driver for a bank of common-anode 7-segment digits, replacing the per-digit combinational hex decoder. A parametrised number of 4-bit hex nibbles is captured into a shadow register. One digit is refreshed at a time with anti-ghosting dead time. Per-digit blanking, per-digit blinking and leading-zero suppression are provided. The block sits between game/score logic and the board's segment and anode pins.

## Interface
- DIGITS, 4: number of digits scanned (1–8).
- REFRESH_DIV, 50000: clock cycles per digit slot (≥ 4).
- DEAD, 16: cycles at the start of each slot with all anodes off (1 ≤ DEAD < REFRESH_DIV).
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥ 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
- blank_mask  in  DIGITS  1 = digit always dark.
- blink_mask  in  DIGITS  1 = digit dark during blink-off phase.
- lz_suppress  in  1  1 = leading-zero suppression enabled.
- load  in  1  capture value/blank_mask/blink_mask into the shadow registers.
- seg_n  out  7  active-low segments; bit0 = a through bit6 = g.
- an_n  out  DIGITS  active-low digit enables; at most one bit low.
- frame_done  out  1  one-cycle pulse when the digit index wraps DIGITS-1 → 0.

## Operation
- Shadow registers: shadow value, blank and blink masks load on any cycle with load=1. Otherwise they hold. Display uses shadow copies only.
- Slot counter runs 0..REFRESH_DIV-1, then wraps. On wrap, digit index increments, with DIGITS-1 → 0.
- Blink counter runs 0..BLINK_DIV-1. On wrap, blink_phase toggles. Phase 0 = on, phase 1 = off.
- Decode is standard hex, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Leading-zero suppression: with lz_suppress=1, digit i is dark when i>0 and shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never suppressed.
- Dark digit: seg_n = 7'h7F, and an_n still follows the scan.
- Digit i is dark if any of these holds: shadow blank bit i is set; (shadow blink bit i is set and blink_phase = 1); or it is LZ-suppressed.
- Dead time: for slot count < DEAD, an_n = all ones and seg_n = 7'h7F.
- Live window: for slot count ≥ DEAD, an_n has only bit [index] low, and seg_n = decoded or dark pattern for that digit.

## Timing
- Reset (reset=1 at an edge) clears the following:
  - slot counter, index, blink counter, blink_phase = 0;
  - shadow value = 0, shadow masks = 0;
  - seg_n = 7'h7F, an_n = all ones, frame_done = 0.
- Reset has priority over load. Reset mid-slot restarts the scan at digit 0, count 0.
- seg_n, an_n and frame_done are registered. Each reflects the counter/index/shadow state of the preceding cycle (1-cycle latency).
- First cycle after reset release: count = 0, so outputs stay dark. Digit 0 first lights at output cycle DEAD+1 after release.
- load at edge t affects seg_n from edge t+1 onward, mid-slot included. No wait for slot boundary.
- frame_done is high for exactly one cycle: the output cycle following the internal wrap of index DIGITS-1 → 0. Period = DIGITS*REFRESH_DIV.
- Blink phase change takes effect on the next output cycle, regardless of slot position.
- DIGITS=1: index stays 0, and frame_done pulses every REFRESH_DIV cycles.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, DEAD=2, BLINK_DIV=64.
- Reset/scan: assert reset 3 cycles, release, load value=16'h1234 → an_n one-hot low cycles 3–8 of each slot, in the order 1110, 1101, 1011, 0111. seg_n = 7'h19, 7'h30, 7'h24, 7'h79 for digits 0–3. frame_done pulses every 32 cycles.
- Dead time: any slot → an_n = 4'hF and seg_n = 7'h7F for the first 2 output cycles of every slot. Never two anodes low.
- LZ suppression: value=16'h0050, lz_suppress=1 → digits 3 and 2 dark, digit 1 = 7'h12, digit 0 = 7'h40. With value=0, only digit 0 lit with 7'h40. With lz_suppress=0, all digits show 7'h40.
- Blank/blink: blank_mask=4'b0001, blink_mask=4'b1000, value=16'h8888 → digit 0 always 7'h7F. Digit 3 alternates 7'h00 / 7'h7F every 64 cycles. Digits 1–2 steady 7'h00.
- Load mid-slot: value=16'hFFFF shown, then load 16'h000A while digit 0 is in its live window → next output cycle seg_n = 7'h08. Without load, a change of value has no effect.
- Reset mid-operation: reset while digit 2 is live → next cycle an_n=4'hF and seg_n=7'h7F. Shadow is cleared, and digit 0 relights with 7'h40 after DEAD+1 cycles.
